// File: rtl/axitrafficgen_rtl_dma_seq.sv
// rtl/axitrafficgen_rtl_dma_seq.sv - DMA request and stream sequencer for the AXI traffic generator
//
// Purpose: on conf_done, issue one DMA read request and (with write-back enabled)
// one DMA write request of N words. Then stream every read beat through a
// one-entry buffer, add INC, and write it back. acc_done pulses for one cycle
// when the transfer is complete.
//
// Build option: define AXITG_WRITEBACK_EN to enable the write-back path.
// Without it the block generates read-only traffic:
//   - the WR_REQ state is skipped;
//   - read beats are discarded;
//   - all write-side outputs are tied to 0.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   conf_info_reg1 / _reg2        transfer length N (words) / base word index B
//   conf_done                     start pulse, honoured only in IDLE
//   dma_read_ctrl_*               read request   (valid/ready, index, length, size)
//   dma_read_chnl_*               read data      (valid/ready, data)
//   dma_write_ctrl_*              write request  (valid/ready, index, length, size)
//   dma_write_chnl_*              write data     (valid/ready, data)
//   acc_done                      one-cycle completion pulse
//   debug                         {state[2:0], beats counted[28:0]}
module axitrafficgen_rtl_dma_seq #(
   parameter logic [31:0] INC = 32'd1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] conf_info_reg1,
   input  logic [31:0] conf_info_reg2,
   input  logic        conf_done,
   output logic        dma_read_ctrl_valid,
   input  logic        dma_read_ctrl_ready,
   output logic [31:0] dma_read_ctrl_data_index,
   output logic [31:0] dma_read_ctrl_data_length,
   output logic [2:0]  dma_read_ctrl_data_size,
   input  logic        dma_read_chnl_valid,
   output logic        dma_read_chnl_ready,
   input  logic [31:0] dma_read_chnl_data,
   output logic        dma_write_ctrl_valid,
   input  logic        dma_write_ctrl_ready,
   output logic [31:0] dma_write_ctrl_data_index,
   output logic [31:0] dma_write_ctrl_data_length,
   output logic [2:0]  dma_write_ctrl_data_size,
   output logic        dma_write_chnl_valid,
   input  logic        dma_write_chnl_ready,
   output logic [31:0] dma_write_chnl_data,
   output logic        acc_done,
   output logic [31:0] debug
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_REQ = 3'd1,
      WR_REQ = 3'd2,
      XFER   = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t      state;
   logic [31:0] len_q;
   logic [31:0] base_q;
   logic [31:0] rd_cnt;
   logic        rd_hs;

   // Request outputs are Moore: decoded from the state register only.
   assign dma_read_ctrl_valid       = (state == RD_REQ);
   assign dma_read_ctrl_data_index  = (state == RD_REQ) ? base_q : 32'd0;
   assign dma_read_ctrl_data_length = (state == RD_REQ) ? len_q  : 32'd0;
   assign dma_read_ctrl_data_size   = (state == RD_REQ) ? 3'b010 : 3'b000;
   assign acc_done                  = (state == DONE);
   assign rd_hs                     = dma_read_chnl_valid && dma_read_chnl_ready;

`ifdef AXITG_WRITEBACK_EN
   logic [31:0] wr_cnt;
   logic [31:0] buf_data;
   logic        buf_full;
   logic        wr_hs;

   // A full buffer may still take a new beat if it is drained in the same cycle.
   assign dma_read_chnl_ready = (state == XFER) && (rd_cnt < len_q)
                                && (!buf_full || dma_write_chnl_ready);
   assign wr_hs = buf_full && dma_write_chnl_ready;

   assign dma_write_ctrl_valid       = (state == WR_REQ);
   assign dma_write_ctrl_data_index  = (state == WR_REQ) ? (base_q + len_q) : 32'd0;
   assign dma_write_ctrl_data_length = (state == WR_REQ) ? len_q : 32'd0;
   assign dma_write_ctrl_data_size   = (state == WR_REQ) ? 3'b010 : 3'b000;
   assign dma_write_chnl_valid       = buf_full;
   assign dma_write_chnl_data        = buf_data;
   assign debug                      = {state, wr_cnt[28:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         len_q    <= 32'd0;
         base_q   <= 32'd0;
         rd_cnt   <= 32'd0;
         wr_cnt   <= 32'd0;
         buf_data <= 32'd0;
         buf_full <= 1'b0;
      end else begin
         case (state)
            IDLE: if (conf_done) begin
               len_q  <= conf_info_reg1;
               base_q <= conf_info_reg2;
               rd_cnt <= 32'd0;
               wr_cnt <= 32'd0;
               state  <= (conf_info_reg1 == 32'd0) ? DONE : RD_REQ;
            end
            RD_REQ: if (dma_read_ctrl_ready) state <= WR_REQ;
            WR_REQ: if (dma_write_ctrl_ready) state <= XFER;
            XFER: begin
               if (rd_hs) begin
                  rd_cnt   <= rd_cnt + 32'd1;
                  buf_data <= dma_read_chnl_data + INC;
                  buf_full <= 1'b1;
               end else if (wr_hs) begin
                  buf_full <= 1'b0;
               end
               // Leave on the last write so acc_done lands the cycle after it.
               if (wr_hs) begin
                  wr_cnt <= wr_cnt + 32'd1;
                  if (wr_cnt + 32'd1 == len_q) state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
`else
   logic unused_inputs;
   assign unused_inputs = ^{dma_write_ctrl_ready, dma_write_chnl_ready, dma_read_chnl_data};

   assign dma_read_chnl_ready        = (state == XFER) && (rd_cnt < len_q);
   assign dma_write_ctrl_valid       = 1'b0;
   assign dma_write_ctrl_data_index  = 32'd0;
   assign dma_write_ctrl_data_length = 32'd0;
   assign dma_write_ctrl_data_size   = 3'b000;
   assign dma_write_chnl_valid       = 1'b0;
   assign dma_write_chnl_data        = 32'd0;
   assign debug                      = {state, rd_cnt[28:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         len_q  <= 32'd0;
         base_q <= 32'd0;
         rd_cnt <= 32'd0;
      end else begin
         case (state)
            IDLE: if (conf_done) begin
               len_q  <= conf_info_reg1;
               base_q <= conf_info_reg2;
               rd_cnt <= 32'd0;
               state  <= (conf_info_reg1 == 32'd0) ? DONE : RD_REQ;
            end
            RD_REQ: if (dma_read_ctrl_ready) state <= XFER;
            XFER: if (rd_hs) begin
               rd_cnt <= rd_cnt + 32'd1;
               if (rd_cnt + 32'd1 == len_q) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
`endif

endmodule
